// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: arbitrates SRAM waits, taken branches and
// RAW hazards into per-register freeze/flush controls, and keeps saturating debug counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned REG_FILE_DEPTH = 4,
   parameter bit          FWD_EN         = 1'b1,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_FILE_DEPTH-1:0] id_src1,
   input  logic [REG_FILE_DEPTH-1:0] id_src2,
   input  logic                      id_use_src1,
   input  logic                      id_use_src2,
   input  logic [REG_FILE_DEPTH-1:0] exe_dst,
   input  logic                      exe_wb_en,
   input  logic                      exe_mem_read,
   input  logic [REG_FILE_DEPTH-1:0] mem_dst,
   input  logic                      mem_wb_en,
   input  logic                      branch_taken,
   input  logic                      mem_busy,
   output logic                      pc_freeze,
   output logic                      if_id_freeze,
   output logic                      if_id_flush,
   output logic                      id_ex_freeze,
   output logic                      id_ex_flush,
   output logic                      ex_mem_freeze,
   output logic                      mem_wb_flush,
   output logic [1:0]                state,
   output logic [CNT_WIDTH-1:0]      stall_cycles,
   output logic [CNT_WIDTH-1:0]      flush_events
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StFlush   = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] stall_q, stall_d;
   logic [CNT_WIDTH-1:0] flush_q, flush_d;
   logic                 hazard1, hazard2, hazard;
   logic                 flush_inc;

   // Without forwarding any in-flight writer blocks; with it only a load in EX does.
   assign hazard1 = id_use_src1 &
                    ((exe_wb_en & (id_src1 == exe_dst) & (exe_mem_read | !FWD_EN)) |
                     (!FWD_EN & mem_wb_en & (id_src1 == mem_dst)));
   assign hazard2 = id_use_src2 &
                    ((exe_wb_en & (id_src2 == exe_dst) & (exe_mem_read | !FWD_EN)) |
                     (!FWD_EN & mem_wb_en & (id_src2 == mem_dst)));
   // The bubble left in IF/ID after a flush reads as R0 and must not raise a stall.
   assign hazard  = (hazard1 | hazard2) & (state_q != StFlush);

   always_comb begin
      pc_freeze     = 1'b0;
      if_id_freeze  = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_freeze  = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_freeze = 1'b0;
      mem_wb_flush  = 1'b0;
      flush_inc     = 1'b0;
      state_d       = StRun;
      if (rst) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (mem_busy) begin
         pc_freeze     = 1'b1;
         if_id_freeze  = 1'b1;
         id_ex_freeze  = 1'b1;
         ex_mem_freeze = 1'b1;
         mem_wb_flush  = 1'b1;
         state_d       = StMemWait;
      end else if (branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         flush_inc   = 1'b1;
         state_d     = StFlush;
      end else if (hazard) begin
         pc_freeze    = 1'b1;
         if_id_freeze = 1'b1;
         id_ex_flush  = 1'b1;
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (pc_freeze && !(&stall_q)) stall_d = stall_q + CNT_WIDTH'(1);
      if (flush_inc && !(&flush_q)) flush_d = flush_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign state        = state_q;
   assign stall_cycles = stall_q;
   assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Checks pipeline_hazard_ctrl (with and without forwarding) against a rule-level model on every
// cycle, plus directed literal expectations from the test plan.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] id_src1, id_src2, exe_dst, mem_dst;
   logic       id_use_src1, id_use_src2, exe_wb_en, exe_mem_read, mem_wb_en;
   logic       branch_taken, mem_busy;

   logic        pcf[2], ifidf[2], ifidfl[2], idexf[2], idexfl[2], exmemf[2], memwbfl[2];
   logic [1:0]  st[2];
   logic [15:0] stall[2], flush[2];

   int n_cmp = 0;
   int n_bad = 0;

   // Index 0: no forwarding, index 1: forwarding present.
   pipeline_hazard_ctrl #(.REG_FILE_DEPTH(4), .FWD_EN(1'b0), .CNT_WIDTH(16)) u_dut0 (
      .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1),
      .id_use_src2(id_use_src2), .exe_dst(exe_dst), .exe_wb_en(exe_wb_en),
      .exe_mem_read(exe_mem_read), .mem_dst(mem_dst), .mem_wb_en(mem_wb_en),
      .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_freeze(pcf[0]),
      .if_id_freeze(ifidf[0]), .if_id_flush(ifidfl[0]), .id_ex_freeze(idexf[0]),
      .id_ex_flush(idexfl[0]), .ex_mem_freeze(exmemf[0]), .mem_wb_flush(memwbfl[0]),
      .state(st[0]), .stall_cycles(stall[0]), .flush_events(flush[0]));

   pipeline_hazard_ctrl #(.REG_FILE_DEPTH(4), .FWD_EN(1'b1), .CNT_WIDTH(16)) u_dut1 (
      .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1),
      .id_use_src2(id_use_src2), .exe_dst(exe_dst), .exe_wb_en(exe_wb_en),
      .exe_mem_read(exe_mem_read), .mem_dst(mem_dst), .mem_wb_en(mem_wb_en),
      .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_freeze(pcf[1]),
      .if_id_freeze(ifidf[1]), .if_id_flush(ifidfl[1]), .id_ex_freeze(idexf[1]),
      .id_ex_flush(idexfl[1]), .ex_mem_freeze(exmemf[1]), .mem_wb_flush(memwbfl[1]),
      .state(st[1]), .stall_cycles(stall[1]), .flush_events(flush[1]));

   always #5 clk = ~clk;

   // Model state
   int m_state[2];
   int m_stall[2];
   int m_flush[2];

   // {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush, ex_mem_freeze, mem_wb_flush}
   function automatic logic [6:0] model_ctrl(input bit fwd, input int mst);
      bit blocked1, blocked2;
      if (rst)          return 7'b0010101;
      if (mem_busy)     return 7'b1101011;
      if (branch_taken) return 7'b0010100;
      blocked1 = id_use_src1 &&
                 ((exe_wb_en && id_src1 == exe_dst && (exe_mem_read || !fwd)) ||
                  (!fwd && mem_wb_en && id_src1 == mem_dst));
      blocked2 = id_use_src2 &&
                 ((exe_wb_en && id_src2 == exe_dst && (exe_mem_read || !fwd)) ||
                  (!fwd && mem_wb_en && id_src2 == mem_dst));
      if ((blocked1 || blocked2) && mst != 2) return 7'b1100100;
      return 7'b0000000;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         if (n_bad <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [6:0] c;
         c = model_ctrl(i[0], m_state[i]);
         if (rst) begin
            m_state[i] = 0;
            m_stall[i] = 0;
            m_flush[i] = 0;
         end else begin
            if (c[6]) m_stall[i] = (m_stall[i] == 65535) ? 65535 : m_stall[i] + 1;
            if (!mem_busy && branch_taken)
               m_flush[i] = (m_flush[i] == 65535) ? 65535 : m_flush[i] + 1;
            m_state[i] = mem_busy ? 1 : (branch_taken ? 2 : 0);
         end
      end
   end

   logic model_valid = 1'b0;

   always @(negedge clk) begin
      if (model_valid) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("ctrl[%0d]", i),
                {pcf[i], ifidf[i], ifidfl[i], idexf[i], idexfl[i], exmemf[i], memwbfl[i]},
                model_ctrl(i[0], m_state[i]));
            chk($sformatf("state[%0d]", i), st[i], m_state[i]);
            chk($sformatf("stall_cycles[%0d]", i), stall[i], m_stall[i]);
            chk($sformatf("flush_events[%0d]", i), flush[i], m_flush[i]);
         end
      end
   end

   task automatic idle();
      id_src1 = 4'd0; id_src2 = 4'd0; id_use_src1 = 1'b0; id_use_src2 = 1'b0;
      exe_dst = 4'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
      mem_dst = 4'd0; mem_wb_en = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
   endtask

   task automatic load_use(input logic [3:0] r);
      exe_mem_read = 1'b1; exe_wb_en = 1'b1; exe_dst = r; id_src1 = r; id_use_src1 = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      next_cycle();
      model_valid = 1'b1;
      @(negedge clk);
      chk("rst if_id_flush", ifidfl[1], 1);
      chk("rst pc_freeze", pcf[1], 0);
      next_cycle();
      rst = 1'b0;
      chk("reset state", st[1], 0);
      chk("reset stall_cycles", stall[1], 0);

      // Load-use with forwarding
      load_use(4'd3);
      @(negedge clk);
      chk("loaduse pc_freeze", pcf[1], 1);
      chk("loaduse id_ex_flush", idexfl[1], 1);
      next_cycle();
      idle();
      chk("loaduse stall_cycles", stall[1], 1);
      chk("loaduse state", st[1], 0);

      // ALU RAW through EX
      exe_wb_en = 1'b1; exe_dst = 4'd3; id_src1 = 4'd3; id_use_src1 = 1'b1;
      @(negedge clk);
      chk("alu raw fwd pc_freeze", pcf[1], 0);
      chk("alu raw nofwd pc_freeze", pcf[0], 1);
      next_cycle();
      idle();

      // RAW through MEM on src2
      mem_wb_en = 1'b1; mem_dst = 4'd5; id_src2 = 4'd5; id_use_src2 = 1'b1;
      @(negedge clk);
      chk("mem raw nofwd pc_freeze", pcf[0], 1);
      chk("mem raw fwd pc_freeze", pcf[1], 0);
      next_cycle();
      idle();

      // Branch then masked false hazard on R0
      branch_taken = 1'b1;
      @(negedge clk);
      chk("branch if_id_flush", ifidfl[1], 1);
      chk("branch id_ex_flush", idexfl[1], 1);
      next_cycle();
      idle();
      load_use(4'd0);
      chk("branch state", st[1], 2);
      chk("branch flush_events", flush[1], 1);
      @(negedge clk);
      chk("flush masks pc_freeze", pcf[1], 0);
      next_cycle();
      idle();
      chk("after flush state", st[1], 0);

      // SRAM wait with pending branch and load-use
      do_reset();
      mem_busy = 1'b1; branch_taken = 1'b1; load_use(4'd7);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("memwait ex_mem_freeze", exmemf[1], 1);
         chk("memwait if_id_flush", ifidfl[1], 0);
         next_cycle();
      end
      mem_busy = 1'b0;
      chk("memwait state", st[1], 1);
      @(negedge clk);
      chk("release if_id_flush", ifidfl[1], 1);
      chk("release pc_freeze", pcf[1], 0);
      next_cycle();
      idle();
      chk("release state", st[1], 2);
      chk("memwait stall_cycles", stall[1], 4);

      // Reset in the middle of MEMWAIT
      mem_busy = 1'b1;
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("rst memwait pc_freeze", pcf[1], 0);
      chk("rst memwait mem_wb_flush", memwbfl[1], 1);
      chk("rst memwait id_ex_flush", idexfl[1], 1);
      next_cycle();
      rst = 1'b0;
      idle();
      chk("rst memwait state", st[1], 0);
      chk("rst memwait stall_cycles", stall[1], 0);

      // Saturation
      load_use(4'd9);
      repeat (65540) @(posedge clk);
      #1;
      idle();
      chk("sat stall_cycles fwd", stall[1], 16'hFFFF);
      chk("sat stall_cycles nofwd", stall[0], 16'hFFFF);
      next_cycle();
      chk("sat hold", stall[1], 16'hFFFF);
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage ARM pipeline.
- Drives the freeze and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sources of control:
  - data hazards between the ID-stage sources and the EX/MEM destinations;
  - taken branches resolved in EX;
  - SRAM wait states reported by the memory stage.
- Also maintains saturating stall and flush statistics counters for performance debug.

Parameters:
REG_FILE_DEPTH, 4, width of register-file index fields
FWD_EN, 1, 1 = forwarding unit present (stall on load-use only); 0 = stall on any RAW hazard
CNT_WIDTH, 16, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_src1  in  REG_FILE_DEPTH  ID-stage Rn index
id_src2  in  REG_FILE_DEPTH  ID-stage Rm/Rd-store index
id_use_src1  in  1  ID instruction reads src1
id_use_src2  in  1  ID instruction reads src2
exe_dst  in  REG_FILE_DEPTH  EX-stage destination
exe_wb_en  in  1  EX-stage writes back
exe_mem_read  in  1  EX-stage instruction is a load
mem_dst  in  REG_FILE_DEPTH  MEM-stage destination
mem_wb_en  in  1  MEM-stage writes back
branch_taken  in  1  EX-stage B asserted
mem_busy  in  1  SRAM access not complete
pc_freeze  out  1  hold PC
if_id_freeze  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID
id_ex_freeze  out  1  hold ID/EX
id_ex_flush  out  1  clear ID/EX (bubble)
ex_mem_freeze  out  1  hold EX/MEM
mem_wb_flush  out  1  bubble into MEM/WB
state  out  2  FSM state (debug)
stall_cycles  out  CNT_WIDTH  cycles with pc_freeze=1
flush_events  out  CNT_WIDTH  taken branches flushed

Behaviour:
- Clocking: all state updates on posedge clk. rst is synchronous active-high, sampled only at posedge.
- Reset:
  - state<=RUN (2'd0); stall_cycles<=0; flush_events<=0.
  - While rst=1 the control outputs are forced: if_id_flush=1, id_ex_flush=1, mem_wb_flush=1, all freezes 0.
  - Reset mid-stall or mid-flush abandons it; the first cycle after reset is RUN with no masking.
- FSM states: RUN=0, MEMWAIT=1, FLUSH=2 (3 unused, decodes as RUN, next state RUN).
- Control outputs are combinational from the registered state and the current inputs. Priority is mem_busy > branch_taken > data hazard.
- hazard1 = id_use_src1 & ((exe_wb_en & id_src1==exe_dst & (exe_mem_read | !FWD_EN)) | (!FWD_EN & mem_wb_en & id_src1==mem_dst)). hazard2 is identical using src2. hazard = (hazard1 | hazard2) & (state!=FLUSH).
- mem_busy=1 (any state):
  - pc_freeze=if_id_freeze=id_ex_freeze=ex_mem_freeze=1, mem_wb_flush=1; all other outputs 0.
  - next state=MEMWAIT.
  - branch_taken and hazard are ignored; EX is held, so a pending branch is re-presented when mem_busy drops.
- else branch_taken=1:
  - if_id_flush=1, id_ex_flush=1, no freezes (PC loads the target).
  - next state=FLUSH; flush_events+1.
- else hazard=1:
  - pc_freeze=1, if_id_freeze=1, id_ex_flush=1.
  - next state=RUN. The stall repeats every cycle while the condition holds, giving 1 bubble per load-use.
- else: all outputs 0; next state=RUN.
- FLUSH lasts exactly one cycle. It masks hazard detection because IF/ID holds a zeroed bubble whose src fields (R0) would match falsely. Priority of mem_busy and branch_taken still applies inside FLUSH.
- MEMWAIT persists while mem_busy=1 and exits to RUN (or FLUSH if branch_taken) in the first cycle mem_busy=0.
- Statistics counters:
  - stall_cycles increments in every non-reset cycle with pc_freeze=1.
  - Both counters saturate at all-ones with no wrap. Reset wins over increment.

Test Plan:
- Load-use, FWD_EN=1: exe_mem_read=1, exe_wb_en=1, exe_dst=3, id_src1=3, id_use_src1=1 for 1 cycle -> pc_freeze=if_id_freeze=id_ex_flush=1 that cycle; stall_cycles=1; state stays 0.
- ALU RAW, same indices but exe_mem_read=0: FWD_EN=1 -> no stall; FWD_EN=0 -> stall. FWD_EN=0 with mem_wb_en=1, mem_dst=5, id_src2=5, id_use_src2=1 -> stall.
- branch_taken=1 one cycle -> if_id_flush=id_ex_flush=1, flush_events=1, state=2 next cycle. Next cycle, a hazard-matching load with id_src1=0=exe_dst -> no stall, state returns to 0.
- mem_busy high 4 cycles together with branch_taken=1 and a load-use hazard -> 4 cycles of all freezes plus mem_wb_flush, state=1, no branch flush. Cycle 5 (mem_busy=0) -> branch flush, state=2; stall_cycles=4.
- Saturation: force 65540 consecutive hazard cycles -> stall_cycles holds 16'hFFFF.
- rst=1 asserted mid-MEMWAIT with mem_busy=1 -> at next edge state=0, counters 0. While rst=1 all flushes=1 and freezes=0.
